// File: rtl/tpu_sequencer.sv
// TPU instruction sequencer: fetches 16-bit instructions and expands each into buffer/array strobe runs.
// Latency: 2 cycles per instruction (FETCH+DECODE) plus execution; start is ignored while busy.
module tpu_sequencer #(
  parameter  int ARRAY_N = 2,
  parameter  int PC_W    = 8,
  localparam int ROW_W   = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_rd_en,
  input  logic [15:0]       imem_rdata,
  output logic [12:0]       mem_addr,
  output logic              mem_rd_en,
  output logic              load_weight,
  output logic              load_input,
  output logic              valid,
  output logic [ROW_W-1:0]  row_idx,
  output logic              busy,
  output logic              halted,
  output logic              illegal_op
);

  localparam int COMP_CYC = 3 * ARRAY_N - 2;
  localparam int CNT_W    = $clog2(COMP_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LOAD_W, S_LOAD_I, S_COMPUTE, S_HALTED
  } state_t;

  state_t            state, state_n;
  logic [PC_W-1:0]   pc, pc_n;
  logic [12:0]       base_addr, base_n;
  logic [ROW_W-1:0]  row, row_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              ill_n;
  logic              loading_n;

  assign imem_addr = pc;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    base_n  = base_addr;
    row_n   = row;
    cnt_n   = cnt;
    ill_n   = illegal_op;
    case (state)
      S_IDLE: begin
        if (start) begin
          ill_n   = 1'b0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        case (imem_rdata[15:13])
          3'b000: begin
            pc_n    = pc + PC_W'(1);
            state_n = S_FETCH;
          end
          3'b001: begin
            base_n  = imem_rdata[12:0];
            pc_n    = pc + PC_W'(1);
            state_n = S_FETCH;
          end
          3'b010: state_n = S_LOAD_W;
          3'b011: state_n = S_LOAD_I;
          3'b100: begin
            cnt_n   = '0;
            state_n = S_COMPUTE;
          end
          3'b101, 3'b110: begin
            ill_n   = 1'b1;
            pc_n    = pc + PC_W'(1);
            state_n = S_FETCH;
          end
          3'b111: state_n = S_HALTED;
        endcase
      end
      S_LOAD_W, S_LOAD_I: begin
        if (row == ROW_W'(ARRAY_N - 1)) begin
          row_n   = '0;
          pc_n    = pc + PC_W'(1);
          state_n = S_FETCH;
        end else begin
          row_n = row + ROW_W'(1);
        end
      end
      S_COMPUTE: begin
        if (cnt == CNT_W'(COMP_CYC - 1)) begin
          cnt_n   = '0;
          pc_n    = pc + PC_W'(1);
          state_n = S_FETCH;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_HALTED: begin
        if (start) begin
          pc_n    = '0;
          ill_n   = 1'b0;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
    loading_n = (state_n == S_LOAD_W) || (state_n == S_LOAD_I);
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      base_addr   <= '0;
      row         <= '0;
      cnt         <= '0;
      illegal_op  <= 1'b0;
      imem_rd_en  <= 1'b0;
      mem_addr    <= '0;
      mem_rd_en   <= 1'b0;
      load_weight <= 1'b0;
      load_input  <= 1'b0;
      valid       <= 1'b0;
      row_idx     <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      base_addr   <= base_n;
      row         <= row_n;
      cnt         <= cnt_n;
      illegal_op  <= ill_n;
      imem_rd_en  <= (state_n == S_FETCH);
      mem_addr    <= loading_n ? (base_n + 13'(row_n)) : 13'd0;
      mem_rd_en   <= loading_n;
      load_weight <= (state_n == S_LOAD_W);
      load_input  <= (state_n == S_LOAD_I);
      valid       <= (state_n == S_COMPUTE);
      row_idx     <= loading_n ? row_n : '0;
      busy        <= (state_n != S_IDLE) && (state_n != S_HALTED);
      halted      <= (state_n == S_HALTED);
    end
  end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed bench for tpu_sequencer: small programs with hand-computed strobe traces and halt timing.
module tb_tpu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;

  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_rdata = '0;
  logic [12:0] mem_addr;
  logic        mem_rd_en, load_weight, load_input, valid;
  logic [0:0]  row_idx;
  logic        busy, halted, illegal_op;

  logic [1:0]  imem_addr2;
  logic        imem_rd_en2;
  logic [15:0] imem_rdata2 = '0;
  logic [12:0] mem_addr2;
  logic        mem_rd_en2, load_weight2, load_input2, valid2;
  logic [0:0]  row_idx2;
  logic        busy2, halted2, illegal_op2;

  logic [15:0] imem  [0:255];
  logic [15:0] imem2 [0:3];

  always #5 clk = ~clk;

  tpu_sequencer #(.ARRAY_N(2), .PC_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .load_weight(load_weight),
    .load_input(load_input), .valid(valid), .row_idx(row_idx),
    .busy(busy), .halted(halted), .illegal_op(illegal_op)
  );

  tpu_sequencer #(.ARRAY_N(2), .PC_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .imem_addr(imem_addr2), .imem_rd_en(imem_rd_en2), .imem_rdata(imem_rdata2),
    .mem_addr(mem_addr2), .mem_rd_en(mem_rd_en2), .load_weight(load_weight2),
    .load_input(load_input2), .valid(valid2), .row_idx(row_idx2),
    .busy(busy2), .halted(halted2), .illegal_op(illegal_op2)
  );

  // Instruction memories: data returned one cycle after the fetch strobe.
  always @(posedge clk) begin
    if (imem_rd_en)  imem_rdata  <= imem[imem_addr];
    if (imem_rd_en2) imem_rdata2 <= imem2[imem_addr2];
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int n_lw, n_li, n_val, n_mrd, viol, halt_at, vruns, vmax, cur_run;
  logic ill_first;
  logic [12:0] addr_q[$];
  int row_q[$];

  function automatic logic [31:0] all_outs();
    return {2'b00, imem_addr, imem_rd_en, mem_addr, mem_rd_en, load_weight, load_input,
            valid, row_idx, busy, halted, illegal_op};
  endfunction

  task automatic load_prog(input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] p2, input logic [15:0] p3);
    for (int k = 0; k < 256; k++) imem[k] = 16'hE000;
    imem[0] = p0; imem[1] = p1; imem[2] = p2; imem[3] = p3;
  endtask

  // Pulses start, then samples each negedge until halted (halt_at = sample index) or budget expires.
  task automatic run(input int max_cyc, input bit poke, input bit rst_lw2);
    n_lw = 0; n_li = 0; n_val = 0; n_mrd = 0; viol = 0; halt_at = -1;
    vruns = 0; vmax = 0; cur_run = 0; ill_first = 1'bx;
    addr_q.delete(); row_q.delete();
    @(negedge clk); start = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); start = 1'b0;
      if (i == 0) ill_first = illegal_op;
      if (load_weight) n_lw++;
      if (load_input) n_li++;
      if (valid) n_val++;
      if (mem_rd_en) begin
        n_mrd++;
        addr_q.push_back(mem_addr);
        row_q.push_back(int'(row_idx));
      end
      if (valid) cur_run++;
      else if (cur_run > 0) begin
        vruns++;
        if (cur_run > vmax) vmax = cur_run;
        cur_run = 0;
      end
      if (int'(load_weight) + int'(load_input) + int'(valid) > 1) viol++;
      if ((load_weight || load_input || valid) && (imem_rd_en || halted || !busy)) viol++;
      if (poke && valid && n_val == 2) start = 1'b1;
      if (rst_lw2 && load_weight && n_lw == 2) begin
        reset = 1'b0;
        halt_at = i;
        break;
      end
      if (halted) begin
        halt_at = i;
        break;
      end
    end
  endtask

  logic [1:0] pc2_q[$];
  int busy2_drops;

  initial begin
    for (int k = 0; k < 4; k++) imem2[k] = 16'h0000;
    load_prog(16'hE000, 16'hE000, 16'hE000, 16'hE000);

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("reset_outs", all_outs(), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("idle_outs", all_outs(), 32'd0);

    // LOAD_ADDR 5, LOAD_WEIGHT, HALT
    load_prog(16'h2005, 16'h4000, 16'hE000, 16'hE000);
    run(50, 1'b0, 1'b0);
    check_eq("t1_halt_at", 32'(halt_at), 32'd8);
    check_eq("t1_n_lw", 32'(n_lw), 32'd2);
    check_eq("t1_other", 32'(n_li + n_val), 32'd0);
    check_eq("t1_addr_cnt", 32'(addr_q.size()), 32'd2);
    check_eq("t1_addr0", 32'(addr_q[0]), 32'd5);
    check_eq("t1_addr1", 32'(addr_q[1]), 32'd6);
    check_eq("t1_row0", 32'(row_q[0]), 32'd0);
    check_eq("t1_row1", 32'(row_q[1]), 32'd1);
    check_eq("t1_pc", 32'(imem_addr), 32'd2);
    check_eq("t1_flags", {29'd0, busy, halted, illegal_op}, 32'b010);
    check_eq("t1_viol", 32'(viol), 32'd0);

    // base_address survives HALTED -> start
    load_prog(16'h4000, 16'hE000, 16'hE000, 16'hE000);
    run(50, 1'b0, 1'b0);
    check_eq("persist_addr0", 32'(addr_q[0]), 32'd5);
    check_eq("persist_addr1", 32'(addr_q[1]), 32'd6);
    check_eq("persist_halt_at", 32'(halt_at), 32'd6);

    // LOAD_ADDR 16, LOAD_INPUTS, COMPUTE, HALT
    load_prog(16'h2010, 16'h6000, 16'h8000, 16'hE000);
    run(60, 1'b0, 1'b0);
    check_eq("t2_halt_at", 32'(halt_at), 32'd14);
    check_eq("t2_n_li", 32'(n_li), 32'd2);
    check_eq("t2_n_lw", 32'(n_lw), 32'd0);
    check_eq("t2_addr0", 32'(addr_q[0]), 32'd16);
    check_eq("t2_addr1", 32'(addr_q[1]), 32'd17);
    check_eq("t2_n_val", 32'(n_val), 32'd4);
    check_eq("t2_vruns", 32'(vruns), 32'd1);
    check_eq("t2_vmax", 32'(vmax), 32'd4);
    check_eq("t2_pc", 32'(imem_addr), 32'd3);
    check_eq("t2_viol", 32'(viol), 32'd0);

    // Illegal opcode, then restart clears the sticky flag
    load_prog(16'hA000, 16'hE000, 16'hE000, 16'hE000);
    run(50, 1'b0, 1'b0);
    check_eq("t3_halt_at", 32'(halt_at), 32'd4);
    check_eq("t3_illegal", 32'(illegal_op), 32'd1);
    check_eq("t3_no_strobes", 32'(n_lw + n_li + n_val + n_mrd), 32'd0);
    check_eq("t3_pc", 32'(imem_addr), 32'd1);
    load_prog(16'hC000, 16'hE000, 16'hE000, 16'hE000);
    run(50, 1'b0, 1'b0);
    check_eq("t3_restart_clr", 32'(ill_first), 32'd0);
    check_eq("t3_op110_illegal", 32'(illegal_op), 32'd1);

    // start during COMPUTE is ignored
    load_prog(16'h8000, 16'hE000, 16'hE000, 16'hE000);
    run(50, 1'b1, 1'b0);
    check_eq("t6_n_val", 32'(n_val), 32'd4);
    check_eq("t6_vruns", 32'(vruns), 32'd1);
    check_eq("t6_halt_at", 32'(halt_at), 32'd8);
    check_eq("t6_pc", 32'(imem_addr), 32'd1);

    // Reset on the second load_weight cycle aborts the sequence
    load_prog(16'h2005, 16'h4000, 16'hE000, 16'hE000);
    run(50, 1'b0, 1'b1);
    check_eq("t4_reset_at", 32'(halt_at), 32'd5);
    @(negedge clk);
    check_eq("t4_outs_zero", all_outs(), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("t4_reset_wins", all_outs(), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t4_still_idle", 32'(busy), 32'd0);
    load_prog(16'h4000, 16'hE000, 16'hE000, 16'hE000);
    run(50, 1'b0, 1'b0);
    check_eq("t4_base_addr0", 32'(addr_q[0]), 32'd0);
    check_eq("t4_base_addr1", 32'(addr_q[1]), 32'd1);

    // PC_W=2 all-NOP program: pc wraps, never idles
    busy2_drops = 0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_rd_en2) pc2_q.push_back(imem_addr2);
      if (!busy2) busy2_drops++;
      @(negedge clk);
    end
    check_eq("t5_fetches", 32'(pc2_q.size()), 32'd10);
    check_eq("t5_pc0", 32'(pc2_q[0]), 32'd0);
    check_eq("t5_pc1", 32'(pc2_q[1]), 32'd1);
    check_eq("t5_pc2", 32'(pc2_q[2]), 32'd2);
    check_eq("t5_pc3", 32'(pc2_q[3]), 32'd3);
    check_eq("t5_pc4_wrap", 32'(pc2_q[4]), 32'd0);
    check_eq("t5_busy", 32'(busy2_drops), 32'd0);
    check_eq("t5_no_halt", 32'(halted2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
